wdt_rsp_ctrl: RTL and testbench
===============================

# wdt_rsp_ctrl

Watchdog response controller: consumes the down-count value produced by the watchdog counter and turns expiries into system-visible actions. It sits between the watchdog counter and the SoC interrupt/reset fabric. On expiry it raises an interrupt first (interrupt-then-reset mode) or goes straight to reset. It then drives a programmable-length system reset pulse. Kicks and interrupt clears from the register block return it to the armed state.

## Interface
Parameters:
- WDT_CNT_WIDTH, 32, width of the counter value being monitored
- RPL_W, 3, width of the reset-pulse-length code

Ports:
- clk  in  1  block clock (same clock as the watchdog counter)
- rst  in  1  reset; synchronous, active-high
- clk_en  in  1  counter update qualifier; timeouts are detected only when high
- cnt  in  WDT_CNT_WIDTH  current watchdog count
- cnt_en  in  1  watchdog enable
- pause  in  1  counter pause (debug halt)
- rsp_mode  in  1  0 = reset on first timeout; 1 = interrupt on first timeout, reset on second
- rpl  in  RPL_W  reset pulse length code; pulse length = 2^(rpl+1) clk cycles (2..256)
- restart  in  1  kick pulse, the same strobe that reloads the counter
- int_clr  in  1  interrupt clear pulse (EOI read)
- wdt_int  out  1  level interrupt
- wdt_sys_rst  out  1  system reset pulse, active-high
- timeout  out  1  one-cycle pulse per accepted timeout
- rsp_state  out  2  current FSM state, for status readback

## Operation
- Timeout event: to = clk_en & cnt_en & ~pause & (cnt == 0) & ~restart.
  - A restart in the same cycle wins, and no timeout is registered.
- FSM states: IDLE=0, ARMED=1, INT_PEND=2, RST_PULSE=3.
- IDLE:
  - cnt_en -> ARMED.
- ARMED:
  - to & rsp_mode -> INT_PEND; set wdt_int.
  - to & ~rsp_mode -> RST_PULSE.
- INT_PEND:
  - to -> RST_PULSE. This has priority over a simultaneous int_clr.
  - Otherwise, restart | int_clr -> ARMED; clear wdt_int.
- RST_PULSE:
  - On entry, rpl is latched and the pulse counter is loaded with 2^(rpl+1)-1.
  - wdt_sys_rst is high for the whole state.
  - The pulse counter decrements every clk cycle; it is not gated by clk_en.
  - At count 0, exit to ARMED if cnt_en, else IDLE; clear wdt_int on exit.
  - In this state, to, restart, int_clr, rsp_mode and rpl changes are all ignored.
- cnt_en low in ARMED or INT_PEND -> IDLE next cycle; clear wdt_int.
- cnt_en low in RST_PULSE does not shorten the pulse.
- timeout pulses for every accepted to, including the one that enters RST_PULSE.
- rsp_mode changes take effect on the next timeout; the current state is kept.

## Timing
- All outputs are registered.
- After rst: rsp_state=IDLE (0); wdt_int, wdt_sys_rst, timeout all 0; pulse counter 0; latched rpl 0.
- Cycle N with to high -> cycle N+1: timeout=1 and state updated. wdt_int or wdt_sys_rst goes high in N+1.
- wdt_sys_rst is high for exactly 2^(rpl+1) consecutive cycles, N+1 .. N+2^(rpl+1).
- rst asserted mid-pulse drops wdt_sys_rst on the next edge. There is no pulse stretching across reset.
- A restart or int_clr in cycle N clears wdt_int in N+1.

## Structure
- Constants go in the shared watchdog parameter include:
  - state encodings
  - RPL_W
  - the pulse counter width, 8 bits (enough for a maximum count of 255)
- One sub-module, wdt_rst_pulse: loadable 8-bit down-counter with a done flag. It is loaded with 2^(rpl+1)-1 and drives wdt_sys_rst.
- The top holds the FSM, timeout qualification and the interrupt flag.

## Test plan
- rsp_mode=0, rpl=0, cnt=0 with clk_en=1 -> timeout pulse; wdt_sys_rst high exactly 2 cycles; return to ARMED; wdt_int stays 0.
- rsp_mode=1, first cnt=0 -> wdt_int=1, state INT_PEND; int_clr -> wdt_int=0 next cycle, ARMED. Second expiry without clear -> wdt_sys_rst for 2^(rpl+1) cycles with rpl=7 (256 cycles).
- cnt=0 with restart=1 in the same cycle -> no timeout, state unchanged. cnt=0 with pause=1 or clk_en=0 -> no timeout.
- INT_PEND with to and int_clr in the same cycle -> RST_PULSE entered, wdt_int held until the pulse ends.
- In RST_PULSE (rpl=2, 8 cycles): change rpl and drop cnt_en mid-pulse -> pulse still 8 cycles, then IDLE. rst in pulse cycle 3 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/wdt_rsp_ctrl_pkg.sv
// Shared watchdog response constants: state encodings, widths and the
// reset-pulse reload helper.
package wdt_rsp_ctrl_pkg;

   localparam int WDT_RPL_W = 3;
   localparam int PCNT_W    = 8;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ARMED     = 2'd1;
   localparam logic [1:0] ST_INT_PEND  = 2'd2;
   localparam logic [1:0] ST_RST_PULSE = 2'd3;

   // Reload value for the pulse counter: 2^(code+1)-1, so the pulse lasts
   // 2^(code+1) cycles including the cycle the counter reads zero.
   function automatic logic [PCNT_W-1:0] pulse_load(input logic [WDT_RPL_W-1:0] code);
      logic [PCNT_W:0] full;
      full = ((PCNT_W+1)'(1) << (int'(code) + 1)) - (PCNT_W+1)'(1);
      return full[PCNT_W-1:0];
   endfunction

endpackage

// File: rtl/wdt_rst_pulse.sv
// Loadable down-counter that times the system reset pulse.
module wdt_rst_pulse
   import wdt_rsp_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [PCNT_W-1:0] load_val,
   output logic              pulse,
   output logic              done
);

   logic [PCNT_W-1:0] cnt_q, cnt_d;
   logic              act_q, act_d;

   // Load starts the pulse; otherwise count down and drop out after zero.
   always_comb begin
      cnt_d = cnt_q;
      act_d = act_q;
      if (load) begin
         cnt_d = load_val;
         act_d = 1'b1;
      end else if (act_q) begin
         if (cnt_q == '0) begin
            act_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Counter and active flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         act_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         act_q <= act_d;
      end
   end

   assign pulse = act_q;
   assign done  = act_q & (cnt_q == '0);

endmodule

// File: rtl/wdt_rsp_ctrl.sv
// Watchdog response controller: qualifies counter expiries and sequences
// interrupt and system reset responses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | watchdog disabled, nothing armed
// ARMED     | watching for the next expiry
// INT_PEND  | first expiry signalled by interrupt; next expiry resets
// RST_PULSE | driving the system reset pulse; all inputs ignored
module wdt_rsp_ctrl
   import wdt_rsp_ctrl_pkg::*;
#(
   parameter int WDT_CNT_WIDTH = 32,
   parameter int RPL_W         = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clk_en,
   input  logic [WDT_CNT_WIDTH-1:0] cnt,
   input  logic                     cnt_en,
   input  logic                     pause,
   input  logic                     rsp_mode,
   input  logic [RPL_W-1:0]         rpl,
   input  logic                     restart,
   input  logic                     int_clr,
   output logic                     wdt_int,
   output logic                     wdt_sys_rst,
   output logic                     timeout,
   output logic [1:0]               rsp_state
);

   logic [1:0]           state_q, state_d;
   logic                 int_q, int_d;
   logic                 tmo_q, tmo_d;
   logic [WDT_CNT_WIDTH-1:0] unused_cnt;
   logic [WDT_RPL_W-1:0] rpl_lat_q, rpl_lat_d;
   logic                 to;
   logic                 pulse_load_en;
   logic                 pulse_done;
   logic [PCNT_W-1:0]    pulse_val;

   assign unused_cnt = '0;

   // A kick in the same cycle as the expiry wins.
   assign to = clk_en & cnt_en & ~pause & (cnt == '0) & ~restart;

   // Next-state, interrupt flag, timeout strobe and rpl latch.
   always_comb begin
      state_d       = state_q;
      int_d         = int_q;
      tmo_d         = 1'b0;
      rpl_lat_d     = rpl_lat_q;
      pulse_load_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cnt_en) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (!cnt_en) begin
               state_d = ST_IDLE;
               int_d   = 1'b0;
            end else if (to) begin
               tmo_d = 1'b1;
               if (rsp_mode) begin
                  state_d = ST_INT_PEND;
                  int_d   = 1'b1;
               end else begin
                  state_d       = ST_RST_PULSE;
                  rpl_lat_d     = WDT_RPL_W'(rpl);
                  pulse_load_en = 1'b1;
               end
            end
         end
         ST_INT_PEND: begin
            if (!cnt_en) begin
               state_d = ST_IDLE;
               int_d   = 1'b0;
            end else if (to) begin
               // Second expiry beats a simultaneous clear; interrupt stays up.
               tmo_d         = 1'b1;
               state_d       = ST_RST_PULSE;
               rpl_lat_d     = WDT_RPL_W'(rpl);
               pulse_load_en = 1'b1;
            end else if (restart || int_clr) begin
               state_d = ST_ARMED;
               int_d   = 1'b0;
            end
         end
         default: begin
            if (pulse_done) begin
               state_d = cnt_en ? ST_ARMED : ST_IDLE;
               int_d   = 1'b0;
            end
         end
      endcase
   end

   assign pulse_val = pulse_load(rpl_lat_d);

   // Controller state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         int_q     <= 1'b0;
         tmo_q     <= 1'b0;
         rpl_lat_q <= '0;
      end else begin
         state_q   <= state_d;
         int_q     <= int_d;
         tmo_q     <= tmo_d;
         rpl_lat_q <= rpl_lat_d;
      end
   end

   wdt_rst_pulse u_rst_pulse (
      .clk      (clk),
      .rst      (rst),
      .load     (pulse_load_en),
      .load_val (pulse_val),
      .pulse    (wdt_sys_rst),
      .done     (pulse_done)
   );

   assign wdt_int   = int_q;
   assign timeout   = tmo_q;
   assign rsp_state = state_q;

endmodule

// File: tb/tb_wdt_rsp_ctrl.sv
// Scoreboard bench for wdt_rsp_ctrl: directed stimulus pushes expected
// snapshots, timeout cycles and pulse lengths; a monitor checks them.
module tb_wdt_rsp_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic [31:0] cnt = 32'd5;
   logic        cnt_en = 1'b0;
   logic        pause = 1'b0;
   logic        rsp_mode = 1'b0;
   logic [2:0]  rpl = 3'd0;
   logic        restart = 1'b0;
   logic        int_clr = 1'b0;
   logic        wdt_int, wdt_sys_rst, timeout;
   logic [1:0]  rsp_state;

   wdt_rsp_ctrl #(.WDT_CNT_WIDTH(32), .RPL_W(3)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .cnt(cnt), .cnt_en(cnt_en),
      .pause(pause), .rsp_mode(rsp_mode), .rpl(rpl), .restart(restart),
      .int_clr(int_clr), .wdt_int(wdt_int), .wdt_sys_rst(wdt_sys_rst),
      .timeout(timeout), .rsp_state(rsp_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] st;
      logic       intr;
      logic       srst;
      logic       tmo;
      string      nm;
   } exp_t;

   exp_t exp_q[$];
   int   tmo_q[$];
   int   plen_q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   run = 0;
   bit   mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic expect_at(input int c, input logic [1:0] st, input logic intr,
                            input logic srst, input logic tmo, input string nm);
      exp_t e;
      e.cyc = c; e.st = st; e.intr = intr; e.srst = srst; e.tmo = tmo; e.nm = nm;
      exp_q.push_back(e);
   endtask

   // Monitor: snapshot checks, timeout-pulse matching, reset-pulse lengths.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
               total++;
               if (rsp_state !== exp_q[i].st || wdt_int !== exp_q[i].intr ||
                   wdt_sys_rst !== exp_q[i].srst || timeout !== exp_q[i].tmo) begin
                  bad++;
                  $display("FAIL %s cyc=%0d got st=%0d int=%b srst=%b tmo=%b exp st=%0d int=%b srst=%b tmo=%b",
                           exp_q[i].nm, cyc, rsp_state, wdt_int, wdt_sys_rst, timeout,
                           exp_q[i].st, exp_q[i].intr, exp_q[i].srst, exp_q[i].tmo);
               end
               exp_q.delete(i);
            end
         end
         if (timeout === 1'b1) begin
            total++;
            if (tmo_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_timeout cyc=%0d got timeout=1 exp none", cyc);
            end else begin
               if (tmo_q[0] != cyc) begin
                  bad++;
                  $display("FAIL timeout_cycle got cyc=%0d exp cyc=%0d", cyc, tmo_q[0]);
               end
               void'(tmo_q.pop_front());
            end
         end else if (tmo_q.size() > 0 && tmo_q[0] <= cyc) begin
            total++;
            bad++;
            $display("FAIL missed_timeout cyc=%0d got timeout=0 exp pulse at %0d", cyc, tmo_q[0]);
            void'(tmo_q.pop_front());
         end
         if (wdt_sys_rst === 1'b1) begin
            run++;
         end else if (run > 0) begin
            total++;
            if (plen_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pulse got len=%0d exp none", run);
            end else begin
               if (plen_q[0] != run) begin
                  bad++;
                  $display("FAIL pulse_len got len=%0d exp len=%0d", run, plen_q[0]);
               end
               void'(plen_q.pop_front());
            end
            run = 0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout sim did not finish");
      $fatal(1);
   end

   initial begin
      int b;
      step(); step();
      mon_en = 1'b1;
      expect_at(cyc, 2'd0, 0, 0, 0, "reset_state");
      rst = 1'b0;

      // enable -> ARMED
      b = cyc; cnt_en = 1'b1;
      expect_at(b+1, 2'd1, 0, 0, 0, "arm");
      step();

      // direct reset, rpl=0 -> 2-cycle pulse
      b = cyc; cnt = 0; rsp_mode = 0; rpl = 3'd0;
      tmo_q.push_back(b+1); plen_q.push_back(2);
      expect_at(b+1, 2'd3, 0, 1, 1, "rst_mode0_entry");
      expect_at(b+2, 2'd3, 0, 1, 0, "rst_mode0_last");
      expect_at(b+3, 2'd1, 0, 0, 0, "rst_mode0_exit");
      step(); cnt = 32'd5;
      run_to(b+3);

      // restart same cycle wins
      b = cyc; cnt = 0; restart = 1;
      expect_at(b+1, 2'd1, 0, 0, 0, "restart_wins");
      step(); cnt = 32'd5; restart = 0;

      // pause blocks timeout
      b = cyc; cnt = 0; pause = 1;
      expect_at(b+1, 2'd1, 0, 0, 0, "pause_blocks");
      step(); cnt = 32'd5; pause = 0;

      // clk_en low blocks timeout
      b = cyc; cnt = 0; clk_en = 0;
      expect_at(b+1, 2'd1, 0, 0, 0, "clk_en_blocks");
      step(); cnt = 32'd5; clk_en = 1;

      // interrupt mode, clear with int_clr
      b = cyc; cnt = 0; rsp_mode = 1; rpl = 3'd7;
      tmo_q.push_back(b+1);
      expect_at(b+1, 2'd2, 1, 0, 1, "int_first");
      step(); cnt = 32'd5; int_clr = 1;
      expect_at(b+2, 2'd1, 0, 0, 0, "int_clr");
      step(); int_clr = 0;

      // two expiries without clear -> 256-cycle pulse
      b = cyc; cnt = 0;
      tmo_q.push_back(b+1);
      expect_at(b+1, 2'd2, 1, 0, 1, "int_second_a");
      step(); cnt = 0;
      tmo_q.push_back(b+2); plen_q.push_back(256);
      expect_at(b+2, 2'd3, 1, 1, 1, "rpl7_entry");
      expect_at(b+257, 2'd3, 1, 1, 0, "rpl7_last");
      expect_at(b+258, 2'd1, 0, 0, 0, "rpl7_exit");
      step(); cnt = 32'd5;
      run_to(b+258);

      // INT_PEND: timeout beats simultaneous int_clr
      b = cyc; cnt = 0; rpl = 3'd0;
      tmo_q.push_back(b+1);
      expect_at(b+1, 2'd2, 1, 0, 1, "prio_int");
      step(); cnt = 0; int_clr = 1;
      tmo_q.push_back(b+2); plen_q.push_back(2);
      expect_at(b+2, 2'd3, 1, 1, 1, "prio_rst_entry");
      expect_at(b+3, 2'd3, 1, 1, 0, "prio_int_held");
      expect_at(b+4, 2'd1, 0, 0, 0, "prio_exit");
      step(); cnt = 32'd5; int_clr = 0;
      run_to(b+4);

      // rpl change and cnt_en drop mid-pulse: still 8 cycles, then IDLE
      b = cyc; cnt = 0; rsp_mode = 0; rpl = 3'd2;
      tmo_q.push_back(b+1); plen_q.push_back(8);
      expect_at(b+1, 2'd3, 0, 1, 1, "rpl2_entry");
      expect_at(b+8, 2'd3, 0, 1, 0, "rpl2_last");
      expect_at(b+9, 2'd0, 0, 0, 0, "rpl2_idle");
      step(); cnt = 32'd5; rpl = 3'd7;
      step(); cnt_en = 0;
      run_to(b+9);

      // rst during pulse cycle 3
      b = cyc; cnt_en = 1;
      expect_at(b+1, 2'd1, 0, 0, 0, "rearm");
      step(); cnt = 0; rpl = 3'd2;
      tmo_q.push_back(b+2); plen_q.push_back(3);
      expect_at(b+2, 2'd3, 0, 1, 1, "rstmid_entry");
      step(); cnt = 32'd5;
      step();
      step(); rst = 1;
      expect_at(b+5, 2'd0, 0, 0, 0, "rstmid_cleared");
      step(); rst = 0;

      run_to(cyc + 20);
      foreach (exp_q[i]) begin
         total++; bad++;
         $display("FAIL unchecked_%s got none exp cyc=%0d", exp_q[i].nm, exp_q[i].cyc);
      end
      foreach (tmo_q[i]) begin
         total++; bad++;
         $display("FAIL pending_timeout got none exp cyc=%0d", tmo_q[i]);
      end
      foreach (plen_q[i]) begin
         total++; bad++;
         $display("FAIL pending_pulse got none exp len=%0d", plen_q[i]);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
